display_scan_driver: RTL and testbench
======================================

// Module: display_scan_driver
// PURPOSE
//  Time-multiplexed N-digit seven-segment driver for the alarm clock display path.
//  - Selects one of NUM_SOURCES packed BCD/hex time words (current/alarm/keypad/...).
//  - Scans digits one at a time, adds per-digit blink and leading-zero blanking.
//  - Latches the selected source and blink mask at frame start, so a frame never mixes sources.
// PARAMETERS
//  NUM_DIGITS   4     digits scanned per frame (>=2)
//  NUM_SOURCES  3     selectable time sources (>=2)
//  SCAN_DIV     1000  clk cycles each digit is enabled (>=2)
//  BLINK_FRAMES 64    frames per blink half-period (>=1)
// PORTS
//  clk          in   1                   system clock, rising edge
//  reset        in   1                   asynchronous, active-high
//  src_time     in   NUM_SOURCES*4*NUM_DIGITS  source k at [k*4*NUM_DIGITS +: 4*NUM_DIGITS]; digit i nibble at [i*4 +: 4]; digit 0 rightmost
//  selector     in   SEL_W=max(1,$clog2(NUM_SOURCES))  source index
//  blink_mask   in   NUM_DIGITS          1 = digit blinks
//  lz_blank     in   1                   1 = blank digit NUM_DIGITS-1 when its nibble is 0
//  seg          out  7                   active-high: bit0=a(top), 1=b(upper right), 2=c(lower right), 3=d(bottom), 4=e(lower left), 5=f(upper left), 6=g(middle)
//  digit_en     out  NUM_DIGITS          one-hot, active-high digit enable
//  frame_start  out  1                   1-clk pulse on the frame latch cycle
// BEHAVIOUR
//  Reset (async):
//   - scan_cnt=0, idx=0, frame_reg=0, mask_reg=0, blink_cnt=0, blink_on=1.
//   - seg=0, digit_en=0, frame_start=0.
//  Scan timing:
//   - scan_cnt counts 0..SCAN_DIV-1 and wraps.
//   - On wrap, idx advances 0..NUM_DIGITS-1 and wraps to 0.
//   - Frame = NUM_DIGITS*SCAN_DIV clks.
//  Frame latch (load cycle = idx==0 && scan_cnt==0, incl. first clk after reset):
//   - frame_reg <= selected source; mask_reg <= blink_mask.
//   - frame_start=1 registered on the same edge.
//   - selector/blink_mask changes take effect only at the next load.
//  Blink:
//   - blink_cnt counts load cycles 0..BLINK_FRAMES-1.
//   - On wrap, blink_on toggles; the new phase applies from that frame.
//  Output register (updated every clk):
//   - digit_en <= onehot(idx).
//   - seg <= decode(nibble idx) unless blanked.
//   - On the load cycle the decode reads the selected source and blink_mask directly (bypass).
//   - Latency: seg/digit_en lag idx by exactly 1 clk and always agree with each other.
//  Blanking (seg=7'h00, digit_en still asserted):
//   - mask_reg[idx] && !blink_on;
//   - lz_blank && idx==NUM_DIGITS-1 && nibble==0;
//   - selector >= NUM_SOURCES (invalid) -> every digit blank.
//  Decode: full hex 0-F; 10-F shown as A,b,C,d,E,F.
//  Reset mid-frame: outputs clear immediately; scan restarts at digit 0 with a fresh latch.
// STRUCTURE
//  display_pkg:
//   - SEG_BLANK and SEG_0..SEG_F 7-bit constants.
//   - NIBBLE_W=4.
//   - function onehot(idx).
//  Sub-module sevenseg_hex_decode: combinational 4-bit -> 7-bit decoder using display_pkg constants.
//  Top: scan counter, digit index, blink counter, frame/mask regs, source mux, output reg.
// TESTING (NUM_DIGITS=4, NUM_SOURCES=3, SCAN_DIV=4, BLINK_FRAMES=2)
//  1. Reset held, then released with src1=16'h1234, selector=1:
//     - during reset seg=0, digit_en=0;
//     - 1st clk digit_en=0001, seg=7'b1100110 ('4'), frame_start=1;
//     - digit_en steps every 4 clks; digit3 seg=7'b0000110 ('1'); frame repeats every 16 clks.
//  2. src0=16'h8A0b, selector=0, full frame:
//     - seg per digit 0..3 = 1111100, 0111111, 1110111, 1111111.
//  3. selector 0->1 while idx=2 (src0=0000, src1=1234):
//     - digits 2,3 still show '0';
//     - next frame digit0 shows '4' on its first enabled clk (bypass).
//  4. blink_mask=4'b0011, constant source:
//     - digits 0,1 seg=0 in frames 2,3,6,7 and lit in frames 0,1,4,5;
//     - digit_en keeps cycling; digits 2,3 never blank.
//  5. lz_blank=1:
//     - src=16'h0930 -> digit3 seg=0, digit0 '0' stays lit;
//     - src=16'h1930 -> digit3 '1'.
//  6. selector=3:
//     - seg=0 for every digit from next frame; digit_en still cycles.
//     - Assert reset at idx=2, scan_cnt=1 -> outputs 0 same cycle; after release restart at digit0.

Source files
------------

// File: rtl/display_scan_driver_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display path.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package display_scan_driver_pkg;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned MAX_DIGITS = 32;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;

  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/display_scan_driver_if.sv
// Source/select inputs and segment/digit outputs of the scan driver.
// master drives the time sources, slave is the driver itself.
interface display_scan_driver_if
  import display_scan_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned NUM_SOURCES = 3
);
  localparam int unsigned SEL_W = (NUM_SOURCES > 2) ? $clog2(NUM_SOURCES) : 1;

  logic [NUM_SOURCES*NIBBLE_W*NUM_DIGITS-1:0] src_time;
  logic [SEL_W-1:0]                           selector;
  logic [NUM_DIGITS-1:0]                      blink_mask;
  logic                                       lz_blank;
  logic [6:0]                                 seg;
  logic [NUM_DIGITS-1:0]                      digit_en;
  logic                                       frame_start;

  modport master (
    output src_time, selector, blink_mask, lz_blank,
    input  seg, digit_en, frame_start
  );

  modport slave (
    input  src_time, selector, blink_mask, lz_blank,
    output seg, digit_en, frame_start
  );
endinterface

// File: rtl/display_scan_driver_decode.sv
// Combinational hex nibble to seven-segment pattern (A,b,C,d,E,F for 10-15).
module sevenseg_hex_decode
  import display_scan_driver_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic [6:0]          seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with per-frame source latch,
// digit blink and leading-zero blanking. Outputs are registered, one clk behind idx.
module display_scan_driver
  import display_scan_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned NUM_SOURCES  = 3,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  display_scan_driver_if.slave  bus
);

  localparam int unsigned FRAME_W = NUM_DIGITS * NIBBLE_W;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
  localparam int unsigned BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic                  invalid_q, invalid_d;
  logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  blink_on_q, blink_on_d;
  logic                  primed_q, primed_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  frame_start_q;

  logic                  load, scan_wrap, blank;
  logic [FRAME_W-1:0]    sel_frame;
  logic [NIBBLE_W-1:0]   nibble;
  logic [6:0]            dec_seg;

  assign load      = (idx_q == '0) && (scan_cnt_q == '0);
  assign scan_wrap = (scan_cnt_q == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    sel_frame = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      if (32'(bus.selector) == k) sel_frame = bus.src_time[k*FRAME_W +: FRAME_W];
    end
  end

  always_comb begin
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (scan_wrap) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

    // The first load after reset opens frame 0 rather than ending a frame.
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    primed_d    = primed_q;
    if (load) begin
      primed_d = 1'b1;
      if (primed_q) begin
        if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BLK_W'(1);
        end
      end
    end

    // On the load cycle the latched copies are bypassed with the live inputs.
    frame_d   = load ? sel_frame : frame_q;
    mask_d    = load ? bus.blink_mask : mask_q;
    invalid_d = load ? (32'(bus.selector) >= NUM_SOURCES) : invalid_q;
  end

  assign nibble = frame_d[32'(idx_q)*NIBBLE_W +: NIBBLE_W];

  sevenseg_hex_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  always_comb begin
    blank = (mask_d[idx_q] && !blink_on_d) ||
            (bus.lz_blank && (idx_q == IDX_W'(NUM_DIGITS - 1)) && (nibble == '0)) ||
            invalid_d;
    seg_d      = blank ? SEG_BLANK : dec_seg;
    digit_en_d = NUM_DIGITS'(onehot(32'(idx_q)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      frame_q       <= '0;
      mask_q        <= '0;
      invalid_q     <= 1'b0;
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      primed_q      <= 1'b0;
      seg_q         <= SEG_BLANK;
      digit_en_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      mask_q        <= mask_d;
      invalid_q     <= invalid_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      primed_q      <= primed_d;
      seg_q         <= seg_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= load;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.digit_en    = digit_en_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with 4 digits, 3 sources, 4-clk scan slots
// and 2-frame blink half-period; outputs sampled on the falling edge.
module tb_display_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned NS = 3;
  localparam int unsigned SD = 4;
  localparam int unsigned BF = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pos    = 0;

  always #5 clk = ~clk;

  display_scan_driver_if #(.NUM_DIGITS(ND), .NUM_SOURCES(NS)) bus ();

  display_scan_driver #(
    .NUM_DIGITS   (ND),
    .NUM_SOURCES  (NS),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // pos = rising edges since reset release; outputs after edge pos show slot pos-1.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    pos++;
  endtask

  task automatic align();
    while (pos % 16 != 0) tick();
  endtask

  task automatic set_src(input int k, input logic [15:0] v);
    bus.src_time[k*16 +: 16] = v;
  endtask

  task automatic test_reset();
    bus.src_time   = '0;
    set_src(1, 16'h1234);
    bus.selector   = 2'd1;
    bus.blink_mask = 4'b0000;
    bus.lz_blank   = 1'b0;
    reset          = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.seg !== 7'h00) begin
      errors++; $display("FAIL reset_seg got %h exp 00", bus.seg);
    end
    checks++;
    if (bus.digit_en !== 4'b0000) begin
      errors++; $display("FAIL reset_digit_en got %b exp 0000", bus.digit_en);
    end
    checks++;
    if (bus.frame_start !== 1'b0) begin
      errors++; $display("FAIL reset_frame_start got %b exp 0", bus.frame_start);
    end
    reset = 1'b0;
    pos   = 0;
  endtask

  task automatic test_scan();
    logic [6:0] exp_tab [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    for (int n = 0; n < 32; n++) begin
      int d;
      tick();
      d = ((pos - 1) / 4) % 4;
      checks++;
      if (bus.digit_en !== 4'(1 << d)) begin
        errors++; $display("FAIL scan_digit_en pos=%0d got %b exp %b", pos, bus.digit_en, 4'(1 << d));
      end
      checks++;
      if (bus.seg !== exp_tab[d]) begin
        errors++; $display("FAIL scan_seg pos=%0d got %b exp %b", pos, bus.seg, exp_tab[d]);
      end
      checks++;
      if (bus.frame_start !== ((pos - 1) % 16 == 0)) begin
        errors++; $display("FAIL scan_frame_start pos=%0d got %b", pos, bus.frame_start);
      end
    end
  endtask

  task automatic test_hex_decode();
    logic [6:0] exp_tab [4] = '{7'b1111100, 7'b0111111, 7'b1110111, 7'b1111111};
    align();
    set_src(0, 16'h8A0B);
    bus.selector = 2'd0;
    for (int n = 0; n < 16; n++) begin
      int d;
      tick();
      d = ((pos - 1) / 4) % 4;
      checks++;
      if (bus.seg !== exp_tab[d]) begin
        errors++; $display("FAIL hex_seg digit=%0d got %b exp %b", d, bus.seg, exp_tab[d]);
      end
    end
  endtask

  task automatic test_source_switch();
    align();
    set_src(0, 16'h0000);
    set_src(1, 16'h1234);
    bus.selector = 2'd0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (n == 8) bus.selector = 2'd1;
      checks++;
      if (bus.seg !== 7'h3F) begin
        errors++; $display("FAIL switch_old_frame pos=%0d got %b exp 0111111", pos, bus.seg);
      end
    end
    tick();
    checks++;
    if (bus.seg !== 7'h66) begin
      errors++; $display("FAIL switch_bypass_seg got %b exp 1100110", bus.seg);
    end
    checks++;
    if (bus.digit_en !== 4'b0001) begin
      errors++; $display("FAIL switch_bypass_digit_en got %b exp 0001", bus.digit_en);
    end
  endtask

  task automatic test_blink();
    logic [6:0] exp_tab [4] = '{7'h7F, 7'h07, 7'h7D, 7'h6D};
    @(negedge clk);
    reset = 1'b1;
    set_src(0, 16'h5678);
    bus.selector   = 2'd0;
    bus.blink_mask = 4'b0011;
    @(negedge clk);
    reset = 1'b0;
    pos   = 0;
    for (int n = 0; n < 128; n++) begin
      int d, f;
      logic [6:0] e;
      tick();
      d = ((pos - 1) / 4) % 4;
      f = (pos - 1) / 16;
      e = (d < 2 && (f % 4) >= 2) ? 7'h00 : exp_tab[d];
      checks++;
      if (bus.seg !== e) begin
        errors++; $display("FAIL blink_seg frame=%0d digit=%0d got %b exp %b", f, d, bus.seg, e);
      end
      checks++;
      if (bus.digit_en !== 4'(1 << d)) begin
        errors++; $display("FAIL blink_digit_en pos=%0d got %b exp %b", pos, bus.digit_en, 4'(1 << d));
      end
    end
    bus.blink_mask = 4'b0000;
  endtask

  task automatic test_lz_blank();
    logic [6:0] exp_a [4] = '{7'h3F, 7'h4F, 7'h6F, 7'h00};
    logic [6:0] exp_b [4] = '{7'h3F, 7'h4F, 7'h6F, 7'h06};
    align();
    bus.lz_blank = 1'b1;
    set_src(0, 16'h0930);
    for (int n = 0; n < 16; n++) begin
      int d;
      tick();
      d = ((pos - 1) / 4) % 4;
      checks++;
      if (bus.seg !== exp_a[d]) begin
        errors++; $display("FAIL lz_zero digit=%0d got %b exp %b", d, bus.seg, exp_a[d]);
      end
    end
    set_src(0, 16'h1930);
    for (int n = 0; n < 16; n++) begin
      int d;
      tick();
      d = ((pos - 1) / 4) % 4;
      checks++;
      if (bus.seg !== exp_b[d]) begin
        errors++; $display("FAIL lz_nonzero digit=%0d got %b exp %b", d, bus.seg, exp_b[d]);
      end
    end
    bus.lz_blank = 1'b0;
  endtask

  task automatic test_invalid_sel();
    align();
    bus.selector = 2'd3;
    for (int n = 0; n < 16; n++) begin
      int d;
      tick();
      d = ((pos - 1) / 4) % 4;
      checks++;
      if (bus.seg !== 7'h00) begin
        errors++; $display("FAIL invalid_seg pos=%0d got %b exp 0000000", pos, bus.seg);
      end
      checks++;
      if (bus.digit_en !== 4'(1 << d)) begin
        errors++; $display("FAIL invalid_digit_en pos=%0d got %b exp %b", pos, bus.digit_en, 4'(1 << d));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    align();
    set_src(1, 16'h1234);
    bus.selector = 2'd1;
    repeat (9) tick();
    checks++;
    if (bus.digit_en !== 4'b0100) begin
      errors++; $display("FAIL midreset_pre_digit_en got %b exp 0100", bus.digit_en);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.seg !== 7'h00 || bus.digit_en !== 4'b0000 || bus.frame_start !== 1'b0) begin
      errors++; $display("FAIL midreset_clear got seg=%b en=%b fs=%b exp 0", bus.seg, bus.digit_en, bus.frame_start);
    end
    @(negedge clk);
    reset = 1'b0;
    pos   = 0;
    tick();
    checks++;
    if (bus.digit_en !== 4'b0001 || bus.seg !== 7'h66 || bus.frame_start !== 1'b1) begin
      errors++; $display("FAIL midreset_restart got seg=%b en=%b fs=%b exp 1100110/0001/1", bus.seg, bus.digit_en, bus.frame_start);
    end
    repeat (4) tick();
    checks++;
    if (bus.digit_en !== 4'b0010 || bus.seg !== 7'h4F) begin
      errors++; $display("FAIL midreset_step got seg=%b en=%b exp 1001111/0010", bus.seg, bus.digit_en);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at pos=%0d", pos);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scan();
    test_hex_decode();
    test_source_switch();
    test_blink();
    test_lz_blank();
    test_invalid_sel();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
